// File: rtl/snow64_instr_mem_responder.sv
// Instruction-cache line-fill responder: fetches one 256-bit line as four ascending 64-bit beats.
// Optional last-line buffer is enabled by defining SNOW64_INSTR_MEM_RESPONDER_LAST_LINE_BUFFER_EN.
module snow64_instr_mem_responder #(
   parameter int ADDR_WIDTH = 64,
   parameter int WORD_WIDTH = 64,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_req,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic                  in_flush,
   output logic                  out_valid,
   output logic [LINE_WIDTH-1:0] out_data,
   output logic                  out_overrun,
   output logic                  out_mem_rd_req,
   output logic [ADDR_WIDTH-1:0] out_mem_rd_addr,
   input  logic                  in_mem_rd_valid,
   input  logic [WORD_WIDTH-1:0] in_mem_rd_data
);
   localparam int BEATS            = LINE_WIDTH / WORD_WIDTH;
   localparam int BEAT_BITS        = $clog2(BEATS);
   localparam int LINE_OFFSET_BITS = 5;
   localparam int TAG_WIDTH        = ADDR_WIDTH - LINE_OFFSET_BITS;
   localparam int WORD_SHIFT       = $clog2(WORD_WIDTH / 8);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [BEAT_BITS-1:0]  beat_q;
   logic                  overrun_q;
   logic [WORD_WIDTH-1:0] word_q [BEATS];
   logic                  last_beat;
   logic                  line_hit;
   logic [LINE_OFFSET_BITS-1:0] unused_addr_bits;

   assign unused_addr_bits = in_addr[LINE_OFFSET_BITS-1:0];
   assign last_beat        = (beat_q == BEAT_BITS'(BEATS - 1));

`ifdef SNOW64_INSTR_MEM_RESPONDER_LAST_LINE_BUFFER_EN
   logic [TAG_WIDTH-1:0] tag_q;
   logic                 tag_valid_q;

   assign line_hit = tag_valid_q && (tag_q == in_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS]);

   // Flush wins over the tag load that happens when a fill completes on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q       <= '0;
         tag_valid_q <= 1'b0;
      end else if (in_flush) begin
         tag_valid_q <= 1'b0;
      end else if (state_q == S_WAIT && state_d == S_RESPOND) begin
         tag_q       <= base_q[ADDR_WIDTH-1:LINE_OFFSET_BITS];
         tag_valid_q <= 1'b1;
      end
   end
`else
   logic unused_flush;
   assign unused_flush = in_flush;
   assign line_hit     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (in_req) state_d = line_hit ? S_RESPOND : S_ISSUE;
         S_ISSUE:   state_d = S_WAIT;
         S_WAIT:    if (in_mem_rd_valid) state_d = last_beat ? S_RESPOND : S_ISSUE;
         S_RESPOND: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out_mem_rd_req = (state_q == S_ISSUE);
      out_valid      = (state_q == S_RESPOND);
   end

   // Beats arriving outside WAIT are stray and must not touch the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q    <= '0;
         beat_q    <= '0;
         overrun_q <= 1'b0;
         word_q    <= '{default: '0};
      end else begin
         if (state_q == S_IDLE && in_req && !line_hit) begin
            base_q <= {in_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
            beat_q <= '0;
         end
         if (state_q == S_WAIT && in_mem_rd_valid) begin
            word_q[beat_q] <= in_mem_rd_data;
            if (!last_beat) beat_q <= beat_q + BEAT_BITS'(1);
         end
         if (state_q != S_IDLE && in_req) overrun_q <= 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_line
         assign out_data[gi*WORD_WIDTH +: WORD_WIDTH] = word_q[gi];
      end
   endgenerate

   assign out_mem_rd_addr = base_q + (ADDR_WIDTH'(beat_q) << WORD_SHIFT);
   assign out_overrun     = overrun_q;

endmodule

// File: tb/tb_snow64_instr_mem_responder.sv
// Self-checking bench for snow64_instr_mem_responder: directed and randomized line fills
// against a line-level reference model (expected line, beat addresses, latency, overrun).
module tb_snow64_instr_mem_responder;
   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_req;
   logic [63:0]   in_addr;
   logic          in_flush;
   logic          out_valid;
   logic [255:0]  out_data;
   logic          out_overrun;
   logic          out_mem_rd_req;
   logic [63:0]   out_mem_rd_addr;
   logic          in_mem_rd_valid;
   logic [63:0]   in_mem_rd_data;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [255:0] model_line;
   bit           model_overrun;
   bit           model_tv;
   logic [58:0]  model_tag;

   always #5 clk = ~clk;

   snow64_instr_mem_responder dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_req          (in_req),
      .in_addr         (in_addr),
      .in_flush        (in_flush),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .out_overrun     (out_overrun),
      .out_mem_rd_req  (out_mem_rd_req),
      .out_mem_rd_addr (out_mem_rd_addr),
      .in_mem_rd_valid (in_mem_rd_valid),
      .in_mem_rd_data  (in_mem_rd_data)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One line request issued at the current negedge, followed cycle by cycle while
   // acting as a memory that answers each beat request 1 (+stall) cycles later.
   task automatic fill(input logic [63:0] addr, input bit fixed, input int stall_beat,
                       input int stall_len, input int overrun_cycle, input int reset_cycle);
      logic [63:0]  base;
      logic [63:0]  words [4];
      logic [255:0] exp_line;
      bit           hit;
      int           extra, exp_lat, exp_reads, exp_valid_cnt, exp_valid_cyc;
      int           countdown, pend_idx, reads, valid_cnt, valid_cyc, last_cyc;

      base = {addr[63:5], 5'b0};
      hit  = 1'b0;
`ifdef SNOW64_INSTR_MEM_RESPONDER_LAST_LINE_BUFFER_EN
      hit = model_tv && (model_tag == addr[63:5]);
`endif
      for (int k = 0; k < 4; k++) begin
         if (fixed) words[k] = {16{4'(k + 1)}};
         else       words[k] = {$urandom, $urandom};
      end
      exp_line = model_line;
      if (!hit) for (int k = 0; k < 4; k++) exp_line[64*k +: 64] = words[k];

      extra         = (stall_beat >= 0 && !hit) ? stall_len : 0;
      exp_lat       = hit ? 1 : 9 + extra;
      exp_reads     = hit ? 0 : 4;
      exp_valid_cnt = 1;
      exp_valid_cyc = exp_lat;
      if (reset_cycle > 0) begin
         exp_reads     = reset_cycle / 2;
         exp_valid_cnt = 0;
         exp_valid_cyc = -1;
         exp_line      = '0;
      end
      last_cyc = exp_lat + 3;

      in_req  = 1'b1;
      in_addr = addr;
      @(negedge clk);
      in_req = 1'b0;

      countdown = 0; pend_idx = 0; reads = 0; valid_cnt = 0; valid_cyc = -1;
      for (int cyc = 1; cyc <= last_cyc; cyc++) begin
         if (out_valid) begin
            valid_cnt++;
            if (valid_cyc < 0) valid_cyc = cyc;
            check("line_at_valid", out_data, exp_line);
         end
         in_mem_rd_valid = 1'b0;
         in_mem_rd_data  = {$urandom, $urandom};
         if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
               in_mem_rd_valid = 1'b1;
               in_mem_rd_data  = words[pend_idx];
            end
         end
         if (out_mem_rd_req) begin
            check("rd_addr", 256'(out_mem_rd_addr), 256'(base + 64'(8 * reads)));
            pend_idx  = reads;
            countdown = 1 + ((reads == stall_beat) ? stall_len : 0);
            reads++;
         end
         in_req = 1'b0;
         if (cyc == overrun_cycle) begin
            in_req        = 1'b1;
            in_addr       = {$urandom, $urandom};
            model_overrun = 1'b1;
         end
         if (cyc == reset_cycle) begin
            rst_n = 1'b0;
            #1;
            check("rst_valid", 256'(out_valid), 256'(0));
            check("rst_data", out_data, 256'(0));
            check("rst_overrun", 256'(out_overrun), 256'(0));
            check("rst_rd_req", 256'(out_mem_rd_req), 256'(0));
            check("rst_rd_addr", 256'(out_mem_rd_addr), 256'(0));
            model_overrun = 1'b0;
            model_tv      = 1'b0;
         end else if (reset_cycle > 0 && cyc == reset_cycle + 1) begin
            rst_n = 1'b1;
         end
         @(negedge clk);
      end
      in_req          = 1'b0;
      in_mem_rd_valid = 1'b0;

      model_line = exp_line;
      if (!hit && reset_cycle <= 0) begin
         model_tv  = 1'b1;
         model_tag = base[63:5];
      end
      check("valid_pulses", 256'(valid_cnt), 256'(exp_valid_cnt));
      check("latency", 256'(valid_cyc), 256'(exp_valid_cyc));
      check("reads", 256'(reads), 256'(exp_reads));
      check("line_after", out_data, model_line);
      check("overrun", 256'(out_overrun), 256'(model_overrun));
      $display("fill addr=%h hit=%0d stall_beat=%0d stall=%0d reads=%0d latency=%0d",
               addr, hit, stall_beat, extra, reads, valid_cyc);
   endtask

   initial begin
      int sb;
      logic [63:0] ra, prev;
      rst_n = 1'b0; in_req = 1'b0; in_addr = '0; in_flush = 1'b0;
      in_mem_rd_valid = 1'b0; in_mem_rd_data = '0;
      model_line = '0; model_overrun = 1'b0; model_tv = 1'b0; model_tag = '0;

      repeat (3) @(negedge clk);
      check("reset_valid", 256'(out_valid), 256'(0));
      check("reset_data", out_data, 256'(0));
      check("reset_overrun", 256'(out_overrun), 256'(0));
      check("reset_rd_req", 256'(out_mem_rd_req), 256'(0));
      check("reset_rd_addr", 256'(out_mem_rd_addr), 256'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // basic fill with the fixed 0x11../0x22../0x33../0x44.. pattern
      fill(64'h1000, 1'b1, -1, 0, -1, -1);
      // unaligned request
      fill(64'h201C, 1'b0, -1, 0, -1, -1);

      // stray beat while idle must not reach the line
      in_mem_rd_valid = 1'b1;
      in_mem_rd_data  = 64'hDEAD;
      @(negedge clk);
      in_mem_rd_valid = 1'b0;
      @(negedge clk);
      check("stray_beat", out_data, model_line);
      $display("stray beat in idle, line=%h", out_data);

      // stalled beat 2
      fill(64'h0000_0000_0004_2040, 1'b0, 2, 5, -1, -1);
      // overrun during WAIT of beat 1, stays sticky across the next fill
      fill(64'h0000_0000_0000_5000, 1'b0, -1, 0, 4, -1);
      fill(64'hFFFF_FFFF_FFFF_FFE7, 1'b0, 0, 2, -1, -1);
      // reset in WAIT of beat 2 with that beat arriving after release
      fill(64'h0000_0000_0000_6000, 1'b0, 2, 3, -1, 6);
      fill(64'h3000, 1'b0, -1, 0, -1, -1);

      // flush pulse, then re-request the same line
      in_flush = 1'b1;
      @(negedge clk);
      in_flush = 1'b0;
      model_tv = 1'b0;
      fill(64'h3000, 1'b0, -1, 0, -1, -1);

`ifdef SNOW64_INSTR_MEM_RESPONDER_LAST_LINE_BUFFER_EN
      fill(64'h1000, 1'b0, -1, 0, -1, -1);
      fill(64'h1004, 1'b0, -1, 0, -1, -1);
      in_flush = 1'b1;
      @(negedge clk);
      in_flush = 1'b0;
      model_tv = 1'b0;
      fill(64'h1000, 1'b0, -1, 0, -1, -1);
`endif

      // randomized fills, sometimes revisiting the previous line
      prev = 64'h3000;
      for (int i = 0; i < 10; i++) begin
         ra = ($urandom_range(0, 2) == 0) ? (prev ^ 64'(($urandom & 31))) : {$urandom, $urandom};
         sb = $urandom_range(0, 4);
         if (sb == 4) sb = -1;
         fill(ra, 1'b0, sb, $urandom_range(1, 4), -1, -1);
         prev = ra;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
